// File: rtl/gol_next_state.sv
// Conway's Game of Life stepper for a 16x16 board: computes one generation a row per clock,
// then pulses enable_update with the finished board and its population.
module gol_next_state #(
   parameter int unsigned WRAP = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [15:0][15:0]  grid,
   output logic [15:0][15:0]  grid_next,
   output logic               enable_update,
   output logic               busy,
   output logic [15:0]        gen_count,
   output logic [8:0]         alive_count
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [3:0]        row_idx_q, row_idx_d;
   logic [15:0][15:0] grid_next_q, grid_next_d;
   logic [8:0]        alive_q, alive_d;
   logic [15:0]       gen_q, gen_d;

   logic [15:0]       row_new;
   logic [8:0]        row_pop;

   // Off-board cells read as dead unless the board is toroidal.
   function automatic logic cell_at(input logic [15:0][15:0] g, input int r, input int c);
      int rr;
      int cc;
      rr = r;
      cc = c;
      if (WRAP != 0) begin
         rr = (r + 16) % 16;
         cc = (c + 16) % 16;
      end
      if (rr < 0 || rr > 15 || cc < 0 || cc > 15) return 1'b0;
      return g[4'(rr)][4'(cc)];
   endfunction

   always_comb begin
      row_new = '0;
      row_pop = '0;
      for (int c = 0; c < 16; c++) begin : g_col
         logic [3:0] nbrs;
         logic       cur;
         nbrs = '0;
         cur  = grid[row_idx_q][4'(c)];
         for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
               if (dr != 0 || dc != 0) begin
                  nbrs = nbrs + 4'(cell_at(grid, int'(row_idx_q) + dr, c + dc));
               end
            end
         end
         row_new[4'(c)] = (nbrs == 4'd3) || (cur && nbrs == 4'd2);
         row_pop        = row_pop + 9'(row_new[4'(c)]);
      end
   end

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      grid_next_d = grid_next_q;
      alive_d     = alive_q;
      gen_d       = gen_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StCalc;
               row_idx_d = '0;
               alive_d   = '0;
            end
         end
         StCalc: begin
            grid_next_d[row_idx_q] = row_new;
            alive_d                = alive_q + row_pop;
            row_idx_d              = row_idx_q + 4'd1;
            if (row_idx_q == 4'd15) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            gen_d   = gen_q + 16'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         row_idx_q   <= '0;
         grid_next_q <= '0;
         alive_q     <= '0;
         gen_q       <= '0;
      end else begin
         state_q     <= state_d;
         row_idx_q   <= row_idx_d;
         grid_next_q <= grid_next_d;
         alive_q     <= alive_d;
         gen_q       <= gen_d;
      end
   end

   assign grid_next     = grid_next_q;
   assign alive_count   = alive_q;
   assign gen_count     = gen_q;
   assign enable_update = (state_q == StDone);
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_gol_next_state.sv
// Bench for gol_next_state: runs a WRAP=0 and a WRAP=1 instance side by side against a
// padded-board Life model, covering reset, latency, edges, aborts and held start.
module tb_gol_next_state;

   typedef logic [15:0][15:0] grid_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   grid_t       grid = '0;
   grid_t       gn0, gn1;
   logic        en0, en1, busy0, busy1;
   logic [15:0] gc0, gc1;
   logic [8:0]  ac0, ac1;

   int total = 0;
   int bad = 0;

   gol_next_state #(.WRAP(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .grid(grid), .grid_next(gn0),
      .enable_update(en0), .busy(busy0), .gen_count(gc0), .alive_count(ac0)
   );

   gol_next_state #(.WRAP(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .grid(grid), .grid_next(gn1),
      .enable_update(en1), .busy(busy1), .gen_count(gc1), .alive_count(ac1)
   );

   initial forever #5 clk = ~clk;

   // Board surrounded by a one-cell border that is either dead or a toroidal copy.
   function automatic grid_t model_next(input grid_t g, input bit wrap);
      int    pad [0:17][0:17];
      grid_t n;
      int    s;
      n = '0;
      for (int i = 0; i < 18; i++) begin
         for (int j = 0; j < 18; j++) begin
            int sr;
            int sc;
            sr = i - 1;
            sc = j - 1;
            if (wrap) begin
               sr = (sr + 16) % 16;
               sc = (sc + 16) % 16;
               pad[i][j] = int'(g[4'(sr)][4'(sc)]);
            end else if (sr < 0 || sr > 15 || sc < 0 || sc > 15) begin
               pad[i][j] = 0;
            end else begin
               pad[i][j] = int'(g[4'(sr)][4'(sc)]);
            end
         end
      end
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            s = 0;
            for (int a = 0; a < 3; a++)
               for (int b = 0; b < 3; b++) s += pad[r + a][c + b];
            s -= pad[r + 1][c + 1];
            n[4'(r)][4'(c)] = (s == 3) || (pad[r + 1][c + 1] == 1 && s == 2);
         end
      end
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      start = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Pulses start for one edge, then counts edges until enable_update (bounded).
   task automatic run_gen(output int lat);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (!en0 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++;
      if ({gn0, gn1} !== '0 || {ac0, ac1, gc0, gc1} !== '0 || {en0, en1, busy0, busy1} !== 4'b0) begin
         bad++;
         $display("FAIL reset_state: gn0=%h ac0=%0d gc0=%0d en0=%b busy0=%b, required all 0",
                  gn0, ac0, gc0, en0, busy0);
      end
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         total++;
         if (gn0 !== '0 || ac0 !== 9'd0 || gc0 !== 16'd0 || en0 !== 1'b0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold cycle %0d: gn0=%h ac0=%0d gc0=%0d en0=%b busy0=%b, required 0",
                     k, gn0, ac0, gc0, en0, busy0);
         end
      end
   endtask

   task automatic test_blinker();
      grid_t exp;
      logic  eb, ee;
      apply_reset();
      grid = '0;
      grid[7][8] = 1'b1;
      grid[8][8] = 1'b1;
      grid[9][8] = 1'b1;
      exp = '0;
      exp[8][7] = 1'b1;
      exp[8][8] = 1'b1;
      exp[8][9] = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k <= 17; k++) begin
         if (k > 0) tick();
         eb = (k <= 16);
         ee = (k == 16);
         total++;
         if (busy0 !== eb || busy1 !== eb) begin
            bad++;
            $display("FAIL blinker_busy after T+%0d: got %b/%b, required %b", k, busy0, busy1, eb);
         end
         total++;
         if (en0 !== ee || en1 !== ee) begin
            bad++;
            $display("FAIL blinker_enable after T+%0d: got %b/%b, required %b", k, en0, en1, ee);
         end
         if (k == 16) begin
            total++;
            if (gn0 !== exp || gn1 !== exp) begin
               bad++;
               $display("FAIL blinker_grid: got %h / %h, required %h", gn0, gn1, exp);
            end
            total++;
            if (ac0 !== 9'd3 || ac1 !== 9'd3) begin
               bad++;
               $display("FAIL blinker_alive: got %0d/%0d, required 3", ac0, ac1);
            end
         end
      end
      total++;
      if (gc0 !== 16'd1 || gc1 !== 16'd1) begin
         bad++;
         $display("FAIL blinker_gen_count: got %0d/%0d, required 1", gc0, gc1);
      end
      tick();
      total++;
      if (gn0 !== exp || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL blinker_idle_hold: gn0=%h busy0=%b, required %h busy 0", gn0, busy0, exp);
      end
   endtask

   task automatic test_still_life();
      int lat;
      grid = '0;
      grid[0][0] = 1'b1;
      grid[0][1] = 1'b1;
      grid[1][0] = 1'b1;
      grid[1][1] = 1'b1;
      run_gen(lat);
      total++;
      if (lat !== 16) begin
         bad++;
         $display("FAIL still_latency: got %0d edges, required 16", lat);
      end
      total++;
      if (gn0 !== grid || gn1 !== grid) begin
         bad++;
         $display("FAIL still_grid: got %h / %h, required %h", gn0, gn1, grid);
      end
      total++;
      if (ac0 !== 9'd4 || ac1 !== 9'd4) begin
         bad++;
         $display("FAIL still_alive: got %0d/%0d, required 4", ac0, ac1);
      end
      tick();
   endtask

   task automatic test_edge();
      grid_t e0, e1;
      int    lat;
      grid = '0;
      grid[0][0] = 1'b1;
      grid[0][1] = 1'b1;
      grid[0][2] = 1'b1;
      e0 = '0;
      e0[0][1] = 1'b1;
      e0[1][1] = 1'b1;
      e1 = e0;
      e1[15][1] = 1'b1;
      run_gen(lat);
      total++;
      if (gn0 !== e0) begin
         bad++;
         $display("FAIL edge_grid_nowrap: got %h, required %h", gn0, e0);
      end
      total++;
      if (gn1 !== e1) begin
         bad++;
         $display("FAIL edge_grid_wrap: got %h, required %h", gn1, e1);
      end
      total++;
      if (ac0 !== 9'd2 || ac1 !== 9'd3) begin
         bad++;
         $display("FAIL edge_alive: got %0d/%0d, required 2/3", ac0, ac1);
      end
      tick();
   endtask

   task automatic test_random();
      grid_t       e0, e1;
      int          lat;
      logic [15:0] gbefore;
      for (int it = 0; it < 8; it++) begin
         for (int r = 0; r < 16; r++) begin
            if (it < 4) grid[r] = 16'($urandom);
            else grid[r] = 16'($urandom) & 16'($urandom);
         end
         e0 = model_next(grid, 1'b0);
         e1 = model_next(grid, 1'b1);
         gbefore = gc0;
         run_gen(lat);
         total++;
         if (lat !== 16) begin
            bad++;
            $display("FAIL rand_latency it%0d: got %0d edges, required 16", it, lat);
         end
         total++;
         if (gn0 !== e0 || gn1 !== e1) begin
            bad++;
            $display("FAIL rand_grid it%0d: got %h / %h, required %h / %h", it, gn0, gn1, e0, e1);
         end
         total++;
         if (ac0 !== 9'($countones(e0)) || ac1 !== 9'($countones(e1))) begin
            bad++;
            $display("FAIL rand_alive it%0d: got %0d/%0d, required %0d/%0d", it, ac0, ac1,
                     $countones(e0), $countones(e1));
         end
         tick();
         total++;
         if (gc0 !== gbefore + 16'd1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL rand_gen_count it%0d: got %0d busy %b, required %0d busy 0", it, gc0,
                     busy0, gbefore + 16'd1);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] gbefore;
      int          pulses;
      gbefore = gc0;
      pulses = 0;
      start = 1'b1;
      tick();
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (en0) pulses++;
      end
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (en0 || busy0) pulses++;
      end
      total++;
      if (pulses !== 1) begin
         bad++;
         $display("FAIL b2b_ignored_start: got %0d active cycles after DONE/pulses, required 1",
                  pulses);
      end
      total++;
      if (gc0 !== gbefore + 16'd1) begin
         bad++;
         $display("FAIL b2b_gen_count: got %0d, required %0d", gc0, gbefore + 16'd1);
      end
   endtask

   task automatic test_midrun_reset();
      int pulses;
      pulses = 0;
      grid = '0;
      grid[7][8] = 1'b1;
      grid[8][8] = 1'b1;
      grid[9][8] = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (en0) pulses++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if (busy0 !== 1'b0 || en0 !== 1'b0 || gn0 !== '0 || gc0 !== 16'd0 || ac0 !== 9'd0) begin
         bad++;
         $display("FAIL midrun_reset_state: busy=%b en=%b gn=%h gc=%0d ac=%0d, required all 0",
                  busy0, en0, gn0, gc0, ac0);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         if (en0 || busy0) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL midrun_no_pulse: got %0d active cycles, required 0", pulses);
      end
   endtask

   task automatic test_held_start();
      logic ee;
      apply_reset();
      grid = '0;
      start = 1'b1;
      for (int e = 0; e < 40; e++) begin
         tick();
         ee = (e == 16 || e == 34);
         total++;
         if (en0 !== ee) begin
            bad++;
            $display("FAIL held_enable after edge %0d: got %b, required %b", e, en0, ee);
         end
         if (ee) begin
            total++;
            if (ac0 !== 9'd0) begin
               bad++;
               $display("FAIL held_alive after edge %0d: got %0d, required 0", e, ac0);
            end
         end
      end
      total++;
      if (gc0 !== 16'd2) begin
         bad++;
         $display("FAIL held_gen_count: got %0d, required 2", gc0);
      end
      start = 1'b0;
      for (int k = 0; k < 20; k++) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_blinker();
      test_still_life();
      test_edge();
      test_random();
      test_back_to_back();
      test_midrun_reset();
      test_held_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gol_next_state.md
GOL_NEXT_STATE -- requirements
Module: gol_next_state

Interface
REQ-001 Parameter: WRAP, default 0, neighbour handling at the board edges: 0 treats off-board cells as dead; 1 makes the board toroidal, wrapping indices modulo 16.
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high; takes priority over all other inputs.
REQ-004 Port: start  input  1  request to compute one generation; sampled only in IDLE.
REQ-005 Port: grid  input  [15:0][15:0]  current board, indexed grid[row][col]; the source shall hold it stable while busy=1.
REQ-006 Port: grid_next  output  [15:0][15:0]  registered next-generation board.
REQ-007 Port: enable_update  output  1  one-cycle pulse; grid_next is complete and valid while it is high.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: gen_count  output  16  count of completed generations.
REQ-010 Port: alive_count  output  9  population of grid_next, range 0..256.

Function
REQ-011 FSM states: IDLE, CALC, DONE; the block shall also hold a 4-bit row_idx register.
REQ-012 In IDLE with start=1 at an edge: go to CALC, set row_idx=0, clear the alive accumulator to 0.
REQ-013 In IDLE with start=0: hold all outputs, including grid_next.
REQ-014 In CALC, each edge writes grid_next[row_idx] and increments row_idx, giving one row per cycle.
REQ-015 In CALC, the alive accumulator shall add the popcount of the written row in 9-bit arithmetic, with no overflow possible.
REQ-016 In CALC, the edge that writes row 15 shall move the FSM to DONE.
REQ-017 Cell rule is B3/S23: a live cell with 2 or 3 live neighbours stays alive; a dead cell with exactly 3 live neighbours becomes alive; every other cell is dead.
REQ-018 Neighbourhood: the 8 surrounding cells, handled at the board edges according to WRAP.
REQ-019 In DONE: enable_update=1 for exactly one cycle, and alive_count equals the total population of grid_next.
REQ-020 At the edge leaving DONE: go to IDLE and increment gen_count by 1; gen_count wraps from 16'hFFFF to 0.
REQ-021 Latency: if start is accepted at edge T, rows 0..15 are written at edges T+1..T+16, enable_update is high between edges T+16 and T+17, and the FSM is back in IDLE after edge T+17.
REQ-022 A start asserted while in CALC or DONE shall be ignored; it is neither queued nor able to restart the computation.
REQ-023 With start held high continuously, a new generation shall begin every 18 cycles, because start is re-sampled at the first IDLE edge after DONE.
REQ-024 grid_next shall change only during CALC; downstream latches grid_next on enable_update, and its grid changes only at the edge that leaves DONE, when this block is already back in IDLE.
REQ-025 If grid changes while busy=1, the output is defined only row-wise: each row is computed from the grid value present in the cycle that row is written.

Reset
REQ-026 When reset=1 at an edge: state=IDLE, row_idx=0, grid_next=0, alive_count=0, gen_count=0, enable_update=0, busy=0.
REQ-027 A reset during CALC or DONE aborts the generation and no enable_update pulse shall occur for it.
REQ-028 When reset and start are both high at the same edge, reset wins and the FSM stays in IDLE.

Verification
REQ-029 Reset scenario: assert reset for 2 cycles -> all outputs 0 and busy=0; afterwards, with start=0, the outputs stay 0 for 10 cycles.
REQ-030 Blinker scenario: grid has live cells at (7,8),(8,8),(9,8); pulse start at edge T ->
  - busy=1 from T+1 through T+17;
  - enable_update is high only between T+16 and T+17;
  - grid_next has live cells exactly at (8,7),(8,8),(8,9);
  - alive_count=3, and gen_count=1 after T+17.
REQ-031 Still-life scenario: grid holds a 2x2 block at (0,0),(0,1),(1,0),(1,1); one generation -> grid_next equals grid and alive_count=4.
REQ-032 Edge scenario: grid has a row-0 horizontal blinker at (0,0),(0,1),(0,2) ->
  - with WRAP=0: grid_next live cells are exactly (0,1),(1,1), and alive_count=2;
  - with WRAP=1: grid_next live cells are exactly (15,1),(0,1),(1,1), and alive_count=3.
REQ-033 Mid-run reset scenario: start a generation, then assert reset when row_idx=8 -> IDLE at the next edge, no enable_update pulse, grid_next=0, gen_count=0.
REQ-034 Held-start scenario: empty grid, start held high for 40 edges from edge 0 ->
  - enable_update pulses only after edges 16 and 34;
  - gen_count=2;
  - alive_count=0 at each pulse.
